// File: rtl/noc_inj_pkg.sv
// Shared parameters, channel/head-flit field layout and FSM state type for the
// local-port packet injector.
package noc_inj_pkg;
    localparam int NUM_VCS     = 4;
    localparam int VC_IDX_W    = 2;
    localparam int BUF_DEPTH   = 8;
    localparam int FLIT_DATA_W = 33;
    localparam int ADDR_W      = 4;
    localparam int LEN_W       = 4;

    localparam int CNT_W       = $clog2(BUF_DEPTH + 1);
    localparam int CHANNEL_W   = 3 + VC_IDX_W + FLIT_DATA_W;
    localparam int FLOW_CTRL_W = 1 + VC_IDX_W;

    // Channel word: {valid, head, tail, vc, data}
    localparam int CH_DATA_LSB  = 0;
    localparam int CH_VC_LSB    = FLIT_DATA_W;
    localparam int CH_TAIL_BIT  = FLIT_DATA_W + VC_IDX_W;
    localparam int CH_HEAD_BIT  = CH_TAIL_BIT + 1;
    localparam int CH_VALID_BIT = CH_TAIL_BIT + 2;
    localparam int FC_VALID_BIT = VC_IDX_W;

    // Head flit payload: {dest, src, len, zero padding}
    localparam int HD_DEST_LSB = FLIT_DATA_W - ADDR_W;
    localparam int HD_SRC_LSB  = HD_DEST_LSB - ADDR_W;
    localparam int HD_LEN_LSB  = HD_SRC_LSB - LEN_W;

    typedef enum logic {IDLE, BODY} state_t;

    function automatic logic [CHANNEL_W-1:0] make_flit(
        input logic                   head,
        input logic                   tail,
        input logic [VC_IDX_W-1:0]    vc,
        input logic [FLIT_DATA_W-1:0] data
    );
        logic [CHANNEL_W-1:0] f;
        f = '0;
        f[CH_VALID_BIT] = 1'b1;
        f[CH_HEAD_BIT]  = head;
        f[CH_TAIL_BIT]  = tail;
        f[CH_VC_LSB +: VC_IDX_W]      = vc;
        f[CH_DATA_LSB +: FLIT_DATA_W] = data;
        return f;
    endfunction
endpackage

// File: rtl/noc_credit_counter.sv
// Credit count for one virtual channel: starts full, decrements on send,
// increments on return, saturates at the downstream buffer depth.
module noc_credit_counter
    import noc_inj_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // overflow is a same-cycle pulse so the owner can register a sticky flag
    // on the very next edge.
    always_comb begin
        count_next = count_reg;
        overflow   = 1'b0;
        if (inc && !dec) begin
            if (count_reg == CNT_W'(BUF_DEPTH)) begin
                overflow = 1'b1;
            end else begin
                count_next = count_reg + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= CNT_W'(BUF_DEPTH);
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/noc_packet_injector.sv
// Network-interface source: turns (dest, len) requests plus payload words into
// head/body/tail flits on one router input, with per-VC credit flow control.
module noc_packet_injector
    import noc_inj_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      router_address,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic [ADDR_W-1:0]      pkt_dest,
    input  logic [LEN_W-1:0]       pkt_len,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [FLIT_DATA_W-1:0] data_in,
    output logic [CHANNEL_W-1:0]   channel_out,
    input  logic [FLOW_CTRL_W-1:0] flow_ctrl_in,
    output logic                   busy,
    output logic                   error
);
    state_t                state_reg, state_next;
    logic [VC_IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [VC_IDX_W-1:0]   cur_vc_reg, cur_vc_next;
    logic [LEN_W-1:0]      remaining_reg, remaining_next;
    logic [CHANNEL_W-1:0]  channel_reg, channel_next;
    logic                  error_reg;

    logic [CNT_W-1:0]      credit [NUM_VCS];
    logic [NUM_VCS-1:0]    has_credit;
    logic [NUM_VCS-1:0]    credit_inc;
    logic [NUM_VCS-1:0]    credit_dec;
    logic [NUM_VCS-1:0]    overflow;

    logic                  sel_found;
    logic [VC_IDX_W-1:0]   sel_vc;
    logic [VC_IDX_W-1:0]   cand_vc;
    logic                  send_head;
    logic                  send_body;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VCS; gi++) begin : g_vc
            assign has_credit[gi] = (credit[gi] != '0);
            assign credit_inc[gi] = flow_ctrl_in[FC_VALID_BIT] &&
                                    (flow_ctrl_in[VC_IDX_W-1:0] == VC_IDX_W'(gi));
            assign credit_dec[gi] = (send_head && (sel_vc == VC_IDX_W'(gi))) ||
                                    (send_body && (cur_vc_reg == VC_IDX_W'(gi)));

            noc_credit_counter u_credit (
                .clk      (clk),
                .reset    (reset),
                .inc      (credit_inc[gi]),
                .dec      (credit_dec[gi]),
                .count    (credit[gi]),
                .overflow (overflow[gi])
            );
        end
    endgenerate

    // Round-robin: first VC with credit, scanning upward from rr_ptr_reg.
    // NUM_VCS is a power of two, so the index wraps naturally.
    always_comb begin
        sel_found = 1'b0;
        sel_vc    = rr_ptr_reg;
        cand_vc   = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            cand_vc = rr_ptr_reg + VC_IDX_W'(i);
            if (!sel_found && has_credit[cand_vc]) begin
                sel_found = 1'b1;
                sel_vc    = cand_vc;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        cur_vc_next    = cur_vc_reg;
        remaining_next = remaining_reg;
        channel_next   = '0;
        pkt_ready      = 1'b0;
        data_ready     = 1'b0;
        send_head      = 1'b0;
        send_body      = 1'b0;
        case (state_reg)
            IDLE: begin
                pkt_ready = !reset && sel_found;
                if (pkt_valid && pkt_ready) begin
                    send_head    = 1'b1;
                    channel_next = make_flit(1'b1, (pkt_len == '0), sel_vc,
                                             {pkt_dest, router_address, pkt_len,
                                              {HD_LEN_LSB{1'b0}}});
                    rr_ptr_next  = sel_vc + VC_IDX_W'(1);
                    if (pkt_len != '0) begin
                        state_next     = BODY;
                        cur_vc_next    = sel_vc;
                        remaining_next = pkt_len;
                    end
                end
            end
            BODY: begin
                // Registered credit only: a return this cycle is usable next cycle.
                data_ready = !reset && has_credit[cur_vc_reg];
                if (data_valid && data_ready) begin
                    send_body      = 1'b1;
                    channel_next   = make_flit(1'b0, (remaining_reg == LEN_W'(1)),
                                               cur_vc_reg, data_in);
                    remaining_next = remaining_reg - LEN_W'(1);
                    if (remaining_reg == LEN_W'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            cur_vc_reg    <= '0;
            remaining_reg <= '0;
            channel_reg   <= '0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            cur_vc_reg    <= cur_vc_next;
            remaining_reg <= remaining_next;
            channel_reg   <= channel_next;
            error_reg     <= error_reg | (|overflow);
        end
    end

    assign channel_out = channel_reg;
    assign busy        = (state_reg == BODY);
    assign error       = error_reg;
endmodule

// File: tb/tb_noc_packet_injector.sv
// Scoreboard bench for noc_packet_injector: expected flits are queued as
// stimulus is driven and popped whenever channel_out carries a valid flit.
module tb_noc_packet_injector;
    logic        clk;
    logic        reset;
    logic [3:0]  router_address;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [3:0]  pkt_dest;
    logic [3:0]  pkt_len;
    logic        data_valid;
    logic        data_ready;
    logic [32:0] data_in;
    logic [37:0] channel_out;
    logic [2:0]  flow_ctrl_in;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [37:0] exp_q[$];

    noc_packet_injector dut (
        .clk            (clk),
        .reset          (reset),
        .router_address (router_address),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_dest       (pkt_dest),
        .pkt_len        (pkt_len),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .data_in        (data_in),
        .channel_out    (channel_out),
        .flow_ctrl_in   (flow_ctrl_in),
        .busy           (busy),
        .error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout reached at cycle %0d", cycle);
        $fatal(1, "timeout");
    end

    function automatic logic [37:0] flit(input logic h, input logic t,
                                         input logic [1:0] vc, input logic [32:0] d);
        return {1'b1, h, t, vc, d};
    endfunction

    // Advance one cycle; sample on the falling edge and score the channel.
    task automatic tick();
        logic [37:0] exp_flit;
        @(negedge clk);
        cycle++;
        if (channel_out[37]) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit cycle %0d got %h required none", cycle, channel_out);
            end else begin
                exp_flit = exp_q.pop_front();
                if (channel_out !== exp_flit) begin
                    errors++;
                    $display("FAIL flit cycle %0d got %h required %h", cycle, channel_out, exp_flit);
                end else begin
                    $display("flit cycle %0d %h ok", cycle, channel_out);
                end
            end
        end else begin
            checks++;
            if (channel_out !== 38'd0) begin
                errors++;
                $display("FAIL idle_channel cycle %0d got %h required 0", cycle, channel_out);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pkt_valid = 1'b0;
        data_valid = 1'b0;
        flow_ctrl_in = 3'b000;
        tick();
        tick();
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic check_credits_full(input string tag);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.credit[i] !== 4'd8) begin
                errors++;
                $display("FAIL %s_credit%0d got %0d required 8", tag, i, dut.credit[i]);
            end
        end
    endtask

    task automatic send_packet(input logic [3:0] dest, input logic [3:0] len,
                               input logic [1:0] vc, input logic [32:0] base);
        int budget;
        int idx;
        logic hs;
        exp_q.push_back(flit(1'b1, (len == 4'd0), vc, {dest, router_address, len, 21'd0}));
        for (int i = 0; i < int'(len); i++)
            exp_q.push_back(flit(1'b0, (i == int'(len) - 1), vc, base + 33'(i)));
        pkt_dest = dest;
        pkt_len = len;
        pkt_valid = 1'b1;
        budget = 0;
        while (!pkt_ready && budget < 20) begin
            tick();
            budget++;
        end
        tick();
        pkt_valid = 1'b0;
        idx = 0;
        data_valid = (len != 4'd0);
        data_in = base;
        budget = 0;
        while (idx < int'(len) && budget < 100) begin
            hs = data_ready;
            tick();
            budget++;
            if (hs) begin
                idx++;
                data_in = base + 33'(idx);
            end
        end
        data_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0 || idx != int'(len)) begin
            errors++;
            $display("FAIL packet_complete dest %0d got pending %0d sent %0d required pending 0 sent %0d",
                     dest, exp_q.size(), idx, len);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (pkt_ready !== 1'b0) begin errors++; $display("FAIL reset_pkt_ready got %b required 0", pkt_ready); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready got %b required 0", data_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b required 0", error); end
        reset = 1'b0;
        tick();
        checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL post_reset_pkt_ready got %b required 1", pkt_ready); end
        check_credits_full("reset");
        $display("test_reset done");
    endtask

    task automatic test_single_flit();
        do_reset();
        exp_q.push_back(flit(1'b1, 1'b1, 2'd0, {4'd5, 4'd3, 4'd0, 21'd0}));
        pkt_dest = 4'd5;
        pkt_len = 4'd0;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_latency got pending %0d required 0", exp_q.size()); end
        checks++; if (channel_out[32:21] !== 12'h530) begin errors++; $display("FAIL single_head_data got %h required 530", channel_out[32:21]); end
        checks++; if (dut.credit[0] !== 4'd7) begin errors++; $display("FAIL single_credit0 got %0d required 7", dut.credit[0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b required 0", busy); end
        $display("test_single_flit done");
    endtask

    task automatic test_body_stream();
        do_reset();
        exp_q.push_back(flit(1'b1, 1'b0, 2'd0, {4'd9, 4'd3, 4'd3, 21'd0}));
        exp_q.push_back(flit(1'b0, 1'b0, 2'd0, 33'hA));
        exp_q.push_back(flit(1'b0, 1'b0, 2'd0, 33'hB));
        exp_q.push_back(flit(1'b0, 1'b1, 2'd0, 33'hC));
        pkt_dest = 4'd9;
        pkt_len = 4'd3;
        pkt_valid = 1'b1;
        data_valid = 1'b1;
        data_in = 33'hA;
        tick();
        pkt_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy got %b required 1", busy); end
        tick();
        data_in = 33'hB;
        tick();
        data_in = 33'hC;
        tick();
        data_valid = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_consecutive got pending %0d required 0", exp_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_after_tail got %b required 0", busy); end
        checks++; if (dut.credit[0] !== 4'd4) begin errors++; $display("FAIL stream_credit0 got %0d required 4", dut.credit[0]); end
        $display("test_body_stream done");
    endtask

    task automatic test_credit_stall();
        do_reset();
        exp_q.push_back(flit(1'b1, 1'b0, 2'd0, {4'd2, 4'd3, 4'd8, 21'd0}));
        for (int i = 0; i < 8; i++)
            exp_q.push_back(flit(1'b0, (i == 7), 2'd0, 33'h100 + 33'(i)));
        pkt_dest = 4'd2;
        pkt_len = 4'd8;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        data_valid = 1'b1;
        data_in = 33'h100;
        for (int i = 1; i <= 7; i++) begin
            tick();
            data_in = 33'h100 + 33'(i);
        end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL stall_data_ready got %b required 0", data_ready); end
        checks++; if (dut.credit[0] !== 4'd0) begin errors++; $display("FAIL stall_credit0 got %0d required 0", dut.credit[0]); end
        tick();
        tick();
        checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL stall_hold got pending %0d required 1", exp_q.size()); end
        flow_ctrl_in = 3'b100;
        tick();
        flow_ctrl_in = 3'b000;
        checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL stall_early_tail got pending %0d required 1", exp_q.size()); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL stall_resume_ready got %b required 1", data_ready); end
        tick();
        data_valid = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_tail_timing got pending %0d required 0", exp_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy got %b required 0", busy); end
        $display("test_credit_stall done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_q.push_back(flit(1'b1, 1'b1, 2'd0, {4'd1, 4'd3, 4'd0, 21'd0}));
        exp_q.push_back(flit(1'b1, 1'b1, 2'd1, {4'd1, 4'd3, 4'd0, 21'd0}));
        pkt_dest = 4'd1;
        pkt_len = 4'd0;
        pkt_valid = 1'b1;
        tick();
        checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL b2b_first got pending %0d required 1", exp_q.size()); end
        tick();
        pkt_valid = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_second got pending %0d required 0", exp_q.size()); end
        $display("test_back_to_back done");
    endtask

    task automatic test_rr_skip();
        do_reset();
        send_packet(4'd4, 4'd7, 2'd0, 33'h200);
        send_packet(4'd4, 4'd7, 2'd1, 33'h300);
        send_packet(4'd4, 4'd0, 2'd2, 33'h0);
        send_packet(4'd4, 4'd0, 2'd3, 33'h0);
        send_packet(4'd4, 4'd0, 2'd2, 33'h0);
        checks++; if (dut.credit[1] !== 4'd0) begin errors++; $display("FAIL rr_credit1 got %0d required 0", dut.credit[1]); end
        checks++; if (dut.credit[2] !== 4'd6) begin errors++; $display("FAIL rr_credit2 got %0d required 6", dut.credit[2]); end
        $display("test_rr_skip done");
    endtask

    task automatic test_overflow();
        do_reset();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovf_pre_error got %b required 0", error); end
        flow_ctrl_in = 3'b110;
        tick();
        flow_ctrl_in = 3'b000;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error got %b required 1", error); end
        checks++; if (dut.credit[2] !== 4'd8) begin errors++; $display("FAIL ovf_credit2 got %0d required 8", dut.credit[2]); end
        tick();
        tick();
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b required 1", error); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovf_reset_clear got %b required 0", error); end
        $display("test_overflow done");
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        exp_q.push_back(flit(1'b1, 1'b0, 2'd0, {4'd6, 4'd3, 4'd5, 21'd0}));
        exp_q.push_back(flit(1'b0, 1'b0, 2'd0, 33'h55));
        pkt_dest = 4'd6;
        pkt_len = 4'd5;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        data_valid = 1'b1;
        data_in = 33'h55;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b required 1", busy); end
        reset = 1'b1;
        tick();
        checks++; if (channel_out !== 38'd0) begin errors++; $display("FAIL mid_channel got %h required 0", channel_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_reset got %b required 0", busy); end
        checks++; if (pkt_ready !== 1'b0) begin errors++; $display("FAIL mid_pkt_ready_in_reset got %b required 0", pkt_ready); end
        reset = 1'b0;
        data_valid = 1'b0;
        tick();
        checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL mid_pkt_ready_after got %b required 1", pkt_ready); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_flits got pending %0d required 0", exp_q.size()); end
        check_credits_full("mid");
        $display("test_reset_mid_packet done");
    endtask

    initial begin
        reset = 1'b1;
        router_address = 4'd3;
        pkt_valid = 1'b0;
        pkt_dest = 4'd0;
        pkt_len = 4'd0;
        data_valid = 1'b0;
        data_in = 33'd0;
        flow_ctrl_in = 3'b000;
        test_reset();
        test_single_flit();
        test_body_stream();
        test_credit_stall();
        test_back_to_back();
        test_rr_skip();
        test_overflow();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
